if_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the decode stage.
- Owns the PC and drives a request/acknowledge instruction-memory port with one request outstanding.
- Holds the IF/ID pipeline register, including a one-entry skid buffer for stalls.
- Redirects fetch on branches resolved early in decode, and delivers instr/pc_plus4 to decode.

---
 rtl/if_stage.sv | 130 +++++++++++++
 tb/tb_if_stage.sv | 121 ++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// if_stage: MIPS instruction fetch with one-outstanding imem handshake, IF/ID register and skid buffer
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_id_o,
  output logic [31:0] pc_plus4_id_o,
  output logic        valid_id_o,
  output logic [31:0] pc_if_o,
  output logic [31:0] fetch_count_o,
  output logic [31:0] bubble_count_o
);
  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_e;
  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, redir_pc_q, redir_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d, skid_pc4_q, skid_pc4_d;
  logic [31:0] instr_q, instr_d, pc4_id_q, pc4_id_d;
  logic [31:0] fetch_q, fetch_d, bubble_q, bubble_d;
  logic        skid_valid_q, skid_valid_d, valid_q, valid_d;
  logic        redir, ack, fresh, skid_load;
  logic [31:0] pc_plus4;
  assign imem_req_o     = (state_q == WAIT) || (state_q == DROP);
  assign imem_addr_o    = pc_q;
  assign redir          = redirect_i & ~stall_i;
  assign ack            = imem_ack_i & imem_req_o;
  assign pc_plus4       = pc_q + 32'd4;
  assign fresh          = (state_q == WAIT) & ack & ~redir;
  assign skid_load      = skid_valid_q & ~flush_i & ~stall_i;
  assign instr_id_o     = instr_q;
  assign pc_plus4_id_o  = pc4_id_q;
  assign valid_id_o     = valid_q;
  assign pc_if_o        = pc_q;
  assign fetch_count_o  = fetch_q;
  assign bubble_count_o = bubble_q;
  // A response arriving in DROP belongs to the squashed path and is discarded.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    redir_pc_d   = redir_pc_q;
    skid_instr_d = skid_instr_q;
    skid_pc4_d   = skid_pc4_q;
    skid_valid_d = (skid_load || redir) ? 1'b0 : skid_valid_q;
    case (state_q)
      IDLE: begin
        pc_d    = redir ? redirect_target_i : pc_q;
        state_d = (redir || !skid_valid_q || skid_load) ? WAIT : IDLE;
      end
      WAIT: begin
        if (ack && !redir) begin
          pc_d = pc_plus4;
          if (stall_i) begin
            skid_instr_d = imem_rdata_i;
            skid_pc4_d   = pc_plus4;
            skid_valid_d = 1'b1;
            state_d      = IDLE;
          end
        end else if (ack) begin
          pc_d = redirect_target_i;
        end else if (redir) begin
          redir_pc_d = redirect_target_i;
          state_d    = DROP;
        end
      end
      DROP: begin
        if (ack) begin
          pc_d    = redir ? redirect_target_i : redir_pc_q;
          state_d = WAIT;
        end else if (redir) begin
          redir_pc_d = redirect_target_i;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    instr_d  = instr_q;
    pc4_id_d = pc4_id_q;
    valid_d  = valid_q;
    fetch_d  = fetch_q;
    bubble_d = bubble_q;
    if (flush_i || (!stall_i && !skid_valid_q && !fresh)) begin
      instr_d  = NOP_INSTR;
      pc4_id_d = 32'd0;
      valid_d  = 1'b0;
      bubble_d = bubble_q + 32'd1;
    end else if (!stall_i) begin
      instr_d  = skid_valid_q ? skid_instr_q : imem_rdata_i;
      pc4_id_d = skid_valid_q ? skid_pc4_q : pc_plus4;
      valid_d  = 1'b1;
      fetch_d  = fetch_q + 32'd1;
    end
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      redir_pc_q   <= 32'd0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= 32'd0;
      skid_pc4_q   <= 32'd0;
      instr_q      <= NOP_INSTR;
      pc4_id_q     <= 32'd0;
      valid_q      <= 1'b0;
      fetch_q      <= 32'd0;
      bubble_q     <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      redir_pc_q   <= redir_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc4_q   <= skid_pc4_d;
      instr_q      <= instr_d;
      pc4_id_q     <= pc4_id_d;
      valid_q      <= valid_d;
      fetch_q      <= fetch_d;
      bubble_q     <= bubble_d;
    end
  end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: cycle-table bench for if_stage with a delivery scoreboard
module tb_if_stage;
  logic        clk = 1'b0;
  logic        reset, stall, flush, redirect, imem_ack;
  logic [31:0] redirect_target, imem_rdata;
  logic        imem_req, valid_id;
  logic [31:0] imem_addr, instr_id, pc_plus4_id, pc_if, fetch_count, bubble_count;
  int          tests = 0;
  int          fails = 0;
  if_stage dut (
    .clk_i(clk), .reset_i(reset), .stall_i(stall), .flush_i(flush),
    .redirect_i(redirect), .redirect_target_i(redirect_target),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr),
    .imem_ack_i(imem_ack), .imem_rdata_i(imem_rdata),
    .instr_id_o(instr_id), .pc_plus4_id_o(pc_plus4_id), .valid_id_o(valid_id),
    .pc_if_o(pc_if), .fetch_count_o(fetch_count), .bubble_count_o(bubble_count)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic        rst, st, fl, rd, ak;
    logic [31:0] tgt;
    logic        req;
    logic [31:0] addr;
    logic        val;
    logic [31:0] instr, pc4;
  } vec_t;
  typedef struct { logic [31:0] instr, pc4; } del_t;
  vec_t vt[33];
  del_t sb[$];
  function automatic vec_t v(input logic rst, st, fl, rd, ak, input logic [31:0] tgt,
                             input logic req, input logic [31:0] addr,
                             input logic val, input logic [31:0] instr, pc4);
    vec_t r;
    r.rst = rst; r.st = st; r.fl = fl; r.rd = rd; r.ak = ak; r.tgt = tgt;
    r.req = req; r.addr = addr; r.val = val; r.instr = instr; r.pc4 = pc4;
    return r;
  endfunction
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  initial begin
    logic [31:0] efc, ebc, prev_fc;
    del_t d;
    vt[0]  = v(1,0,0,0,0,0,            0,0,            0,0,0);
    vt[1]  = v(0,0,0,0,1,0,            0,0,            0,0,0);
    vt[2]  = v(0,0,0,0,1,0,            1,32'h0,        1,32'hA000_0000,32'h4);
    vt[3]  = v(0,0,0,0,1,0,            1,32'h4,        1,32'hA000_0004,32'h8);
    vt[4]  = v(0,1,0,0,1,0,            1,32'h8,        1,32'hA000_0004,32'h8);
    vt[5]  = v(0,1,0,0,0,0,            0,0,            1,32'hA000_0004,32'h8);
    vt[6]  = v(0,1,0,0,0,0,            0,0,            1,32'hA000_0004,32'h8);
    vt[7]  = v(0,0,0,0,0,0,            0,0,            1,32'hA000_0008,32'hC);
    vt[8]  = v(0,0,0,0,1,0,            1,32'hC,        1,32'hA000_000C,32'h10);
    vt[9]  = v(0,0,0,1,0,32'h40,       1,32'h10,       0,0,0);
    vt[10] = v(0,0,0,0,0,0,            1,32'h10,       0,0,0);
    vt[11] = v(0,0,0,0,0,0,            1,32'h10,       0,0,0);
    vt[12] = v(0,0,0,0,1,0,            1,32'h10,       0,0,0);
    vt[13] = v(0,0,0,0,1,0,            1,32'h40,       1,32'hA000_0040,32'h44);
    vt[14] = v(0,0,0,1,1,32'h100,      1,32'h44,       0,0,0);
    vt[15] = v(0,0,0,0,1,0,            1,32'h100,      1,32'hA000_0100,32'h104);
    vt[16] = v(0,1,0,1,1,32'h200,      1,32'h104,      1,32'hA000_0100,32'h104);
    vt[17] = v(0,1,1,0,0,0,            0,0,            0,0,0);
    vt[18] = v(0,0,0,0,0,0,            0,0,            1,32'hA000_0104,32'h108);
    vt[19] = v(0,0,0,0,1,0,            1,32'h108,      1,32'hA000_0108,32'h10C);
    vt[20] = v(1,0,0,0,1,0,            1,32'h10C,      0,0,0);
    vt[21] = v(0,0,0,0,0,0,            0,0,            0,0,0);
    vt[22] = v(0,0,0,0,1,0,            1,32'h0,        1,32'hA000_0000,32'h4);
    vt[23] = v(0,0,0,1,0,32'hFFFF_FFFC,1,32'h4,        0,0,0);
    vt[24] = v(0,0,0,0,1,0,            1,32'h4,        0,0,0);
    vt[25] = v(0,0,0,0,1,0,            1,32'hFFFF_FFFC,1,32'hFFFF_FFFC,32'h0);
    vt[26] = v(0,0,0,0,1,0,            1,32'h0,        1,32'hA000_0000,32'h4);
    vt[27] = v(0,0,0,1,0,32'h80,       1,32'h4,        0,0,0);
    vt[28] = v(0,0,0,1,0,32'h90,       1,32'h4,        0,0,0);
    vt[29] = v(0,0,0,0,1,0,            1,32'h4,        0,0,0);
    vt[30] = v(0,0,0,1,0,32'hC0,       1,32'h90,       0,0,0);
    vt[31] = v(0,0,0,1,1,32'hA0,       1,32'h90,       0,0,0);
    vt[32] = v(0,0,0,0,1,0,            1,32'hA0,       1,32'hA000_00A0,32'hA4);
    reset = 1'b0; stall = 1'b0; flush = 1'b0; redirect = 1'b0; imem_ack = 1'b0;
    redirect_target = '0; imem_rdata = '0;
    efc = '0; ebc = '0; prev_fc = '0;
    @(posedge clk); #1;
    for (int i = 0; i < 33; i++) begin
      reset = vt[i].rst; stall = vt[i].st; flush = vt[i].fl; redirect = vt[i].rd;
      imem_ack = vt[i].ak; redirect_target = vt[i].tgt;
      imem_rdata = vt[i].addr | 32'hA000_0000;
      if (i > 0) begin
        chk($sformatf("r%0d imem_req", i), {31'd0, imem_req}, {31'd0, vt[i].req});
        if (vt[i].req) chk($sformatf("r%0d imem_addr", i), imem_addr, vt[i].addr);
      end
      if (!vt[i].rst && !vt[i].fl && !vt[i].st && vt[i].val) begin
        d.instr = vt[i].instr; d.pc4 = vt[i].pc4;
        sb.push_back(d);
      end
      if (vt[i].rst) begin efc = '0; ebc = '0; end
      else if (vt[i].fl) ebc++;
      else if (!vt[i].st) begin if (vt[i].val) efc++; else ebc++; end
      @(posedge clk); #1;
      chk($sformatf("r%0d valid_id", i), {31'd0, valid_id}, {31'd0, vt[i].val});
      chk($sformatf("r%0d instr_id", i), instr_id, vt[i].instr);
      chk($sformatf("r%0d pc_plus4_id", i), pc_plus4_id, vt[i].pc4);
      chk($sformatf("r%0d fetch_count", i), fetch_count, efc);
      chk($sformatf("r%0d bubble_count", i), bubble_count, ebc);
      if (!vt[i].rst && fetch_count !== prev_fc) begin
        if (sb.size() == 0) chk($sformatf("r%0d sb_unexpected", i), 32'd1, 32'd0);
        else begin
          d = sb.pop_front();
          chk($sformatf("r%0d sb_instr", i), instr_id, d.instr);
          chk($sformatf("r%0d sb_pc4", i), pc_plus4_id, d.pc4);
        end
      end
      prev_fc = fetch_count;
    end
    chk("sb_leftover", sb.size(), 32'd0);
    chk("pc_if_final", pc_if, 32'hA4);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
